// File: rtl/calc_seq_pkg.sv
// Shared types and constants for the calculator sequencer slice.
// Event encodings, FSM state codes, opcode width and the FIFO event record.
package calc_seq_pkg;

    // Opcode width carried by OP events and driven to the arithmetic unit
    localparam int OPW = 2;

    // Decoded key event classes from the keypad interpreter
    typedef enum logic [1:0] {
        EV_HEX = 2'd0,
        EV_OP  = 2'd1,
        EV_EQ  = 2'd2,
        EV_BS  = 2'd3
    } ev_type_e;

    // Sequencer FSM states
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_START = 3'd1;
    localparam state_t ST_WAIT  = 3'd2;
    localparam state_t ST_WRITE = 3'd3;
    localparam state_t ST_PUSH  = 3'd4;
    localparam state_t ST_ERROR = 3'd5;

    // One buffered key event: class plus 4-bit payload
    typedef struct packed {
        logic [1:0] typ;
        logic [3:0] data;
    } event_t;

    localparam int EVW = $bits(event_t);

    // Opcode field of an OP event payload
    function automatic logic [OPW-1:0] ev_opcode(input event_t e);
        return e.data[OPW-1:0];
    endfunction

endpackage

// File: rtl/calc_event_fifo.sv
// Small event FIFO between the keypad interpreter and the sequencer FSM.
// Count-based occupancy; FIFO_DEPTH must be a power of two, at least 2.
// A push while full is accepted only when a pop happens in the same cycle.
module calc_event_fifo
    import calc_seq_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           push,
    input  logic [EVW-1:0] din,
    input  logic           pop,
    output logic [EVW-1:0] dout,
    output logic           full,
    output logic           empty
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

    logic [EVW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count;
    logic           push_ok;
    logic           pop_ok;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign dout    = mem[rd_ptr];

    // Storage array: payload only, no reset needed
    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers and occupancy; pointers wrap naturally at the power-of-two depth
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/calc_sequencer.sv
// Calculator control FSM: pops buffered key events and issues one-cycle
// register-file commands plus a start/done handshake to the arithmetic unit.
// All outputs are registered; each command pulse is high for the cycle that
// follows the edge at which its event was popped.
// Optional build macro CALC_SEQ_STATS_EN adds saturating op_count and
// drop_count outputs.
module calc_sequencer
    import calc_seq_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int ALU_TIMEOUT = 64
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           ev_valid,
    input  logic [1:0]     ev_type,
    input  logic [3:0]     ev_data,
    output logic           ev_drop,
    output logic           hex_we,
    output logic [3:0]     hex_val,
    output logic           bs_we,
    output logic           push_we,
    output logic           ans_we,
    output logic           clr_we,
    output logic           alu_start,
    output logic [OPW-1:0] alu_op,
    input  logic           alu_done,
    input  logic           alu_ovw,
    output logic           busy,
    output logic           err
`ifdef CALC_SEQ_STATS_EN
    ,
    output logic [7:0]     op_count,
    output logic [3:0]     drop_count
`endif
);

    localparam int CW = $clog2(ALU_TIMEOUT + 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(ALU_TIMEOUT - 1);

    // FIFO interface
    event_t ev_in;
    event_t head;
    logic   fifo_full;
    logic   fifo_empty;
    logic   pop;
    logic   push;
    logic   drop_n;

    // FSM state and operand bookkeeping
    state_t         state, state_n;
    logic [CW-1:0]  cnt, cnt_n;
    logic           pend_valid, pend_valid_n;
    logic [OPW-1:0] pend_op, pend_op_n;
    logic [OPW-1:0] next_op, next_op_n;
    logic           chain, chain_n;

    // Next values of the registered outputs
    logic           hex_we_n, bs_we_n, push_we_n, ans_we_n, clr_we_n;
    logic           alu_start_n;
    logic [3:0]     hex_val_n;
    logic [OPW-1:0] alu_op_n;
    logic           busy_n, err_n;

    assign ev_in = {ev_type, ev_data};

    // Only IDLE and ERROR consume events; every other state lets them queue
    assign pop    = !fifo_empty && ((state == ST_IDLE) || (state == ST_ERROR));
    assign push   = ev_valid && (!fifo_full || pop);
    assign drop_n = ev_valid && fifo_full && !pop;

    calc_event_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .din   (ev_in),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Next-state and command decode
    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        pend_valid_n = pend_valid;
        pend_op_n    = pend_op;
        next_op_n    = next_op;
        chain_n      = chain;
        hex_val_n    = hex_val;
        alu_op_n     = alu_op;
        hex_we_n     = 1'b0;
        bs_we_n      = 1'b0;
        push_we_n    = 1'b0;
        ans_we_n     = 1'b0;
        clr_we_n     = 1'b0;
        alu_start_n  = 1'b0;

        case (state)
            ST_IDLE: begin
                if (pop) begin
                    case (head.typ)
                        EV_HEX: begin
                            hex_we_n  = 1'b1;
                            hex_val_n = head.data;
                        end
                        EV_BS: begin
                            bs_we_n = 1'b1;
                        end
                        EV_OP: begin
                            if (!pend_valid) begin
                                push_we_n    = 1'b1;
                                pend_op_n    = ev_opcode(head);
                                pend_valid_n = 1'b1;
                            end else begin
                                chain_n     = 1'b1;
                                next_op_n   = ev_opcode(head);
                                alu_start_n = 1'b1;
                                alu_op_n    = pend_op;
                                state_n     = ST_START;
                            end
                        end
                        EV_EQ: begin
                            if (pend_valid) begin
                                chain_n     = 1'b0;
                                alu_start_n = 1'b1;
                                alu_op_n    = pend_op;
                                state_n     = ST_START;
                            end
                        end
                        default: ;
                    endcase
                end
            end

            ST_START: begin
                cnt_n   = '0;
                state_n = ST_WAIT;
            end

            ST_WAIT: begin
                cnt_n = cnt + 1'b1;
                if (alu_done) begin
                    if (alu_ovw) begin
                        state_n = ST_ERROR;
                    end else begin
                        ans_we_n = 1'b1;
                        state_n  = ST_WRITE;
                    end
                end else if (cnt == TMO_LAST) begin
                    state_n = ST_ERROR;
                end
            end

            ST_WRITE: begin
                if (chain) begin
                    push_we_n = 1'b1;
                    pend_op_n = next_op;
                    state_n   = ST_PUSH;
                end else begin
                    pend_valid_n = 1'b0;
                    state_n      = ST_IDLE;
                end
            end

            ST_PUSH: begin
                state_n = ST_IDLE;
            end

            ST_ERROR: begin
                // Anything but backspace is swallowed while in error
                if (pop && (head.typ == EV_BS)) begin
                    clr_we_n     = 1'b1;
                    pend_valid_n = 1'b0;
                    state_n      = ST_IDLE;
                end
            end

            default: begin
                state_n = ST_IDLE;
            end
        endcase

        busy_n = (state_n != ST_IDLE);
        err_n  = (state_n == ST_ERROR);
    end

    // State, bookkeeping and registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            pend_valid <= 1'b0;
            pend_op    <= '0;
            next_op    <= '0;
            chain      <= 1'b0;
            ev_drop    <= 1'b0;
            hex_we     <= 1'b0;
            hex_val    <= '0;
            bs_we      <= 1'b0;
            push_we    <= 1'b0;
            ans_we     <= 1'b0;
            clr_we     <= 1'b0;
            alu_start  <= 1'b0;
            alu_op     <= '0;
            busy       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            pend_valid <= pend_valid_n;
            pend_op    <= pend_op_n;
            next_op    <= next_op_n;
            chain      <= chain_n;
            ev_drop    <= drop_n;
            hex_we     <= hex_we_n;
            hex_val    <= hex_val_n;
            bs_we      <= bs_we_n;
            push_we    <= push_we_n;
            ans_we     <= ans_we_n;
            clr_we     <= clr_we_n;
            alu_start  <= alu_start_n;
            alu_op     <= alu_op_n;
            busy       <= busy_n;
            err        <= err_n;
        end
    end

`ifdef CALC_SEQ_STATS_EN
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    // Saturating activity counters: completed operations and dropped events
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            op_count   <= '0;
            drop_count <= '0;
        end else begin
            if ((state == ST_WAIT) && (state_n == ST_WRITE)) begin
                op_count <= sat_inc8(op_count);
            end
            if (drop_n) begin
                drop_count <= sat_inc4(drop_count);
            end
        end
    end
`endif

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer with a command scoreboard and an ALU model.
// Optional build macro CALC_SEQ_STATS_EN also checks the statistics outputs.
module tb_calc_sequencer;
    import calc_seq_pkg::*;

    localparam int K_HEX   = 0;
    localparam int K_BS    = 1;
    localparam int K_PUSH  = 2;
    localparam int K_ANS   = 3;
    localparam int K_CLR   = 4;
    localparam int K_START = 5;

    logic       clock;
    logic       reset;
    logic       ev_valid;
    logic [1:0] ev_type;
    logic [3:0] ev_data;
    logic       ev_drop;
    logic       hex_we;
    logic [3:0] hex_val;
    logic       bs_we;
    logic       push_we;
    logic       ans_we;
    logic       clr_we;
    logic       alu_start;
    logic [1:0] alu_op;
    logic       alu_done;
    logic       alu_ovw;
    logic       busy;
    logic       err;
`ifdef CALC_SEQ_STATS_EN
    logic [7:0] op_count;
    logic [3:0] drop_count;
`endif

    int total = 0;
    int bad   = 0;
    int sbq[$];
    int drops_seen = 0;

    // ALU model controls
    int   alu_mode = 2;   // 0 normal, 1 overflow, 2 never answers
    int   alu_lat  = 5;
    logic force_done = 1'b0;

    calc_sequencer #(
        .FIFO_DEPTH  (4),
        .ALU_TIMEOUT (64)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .ev_valid  (ev_valid),
        .ev_type   (ev_type),
        .ev_data   (ev_data),
        .ev_drop   (ev_drop),
        .hex_we    (hex_we),
        .hex_val   (hex_val),
        .bs_we     (bs_we),
        .push_we   (push_we),
        .ans_we    (ans_we),
        .clr_we    (clr_we),
        .alu_start (alu_start),
        .alu_op    (alu_op),
        .alu_done  (alu_done),
        .alu_ovw   (alu_ovw),
        .busy      (busy),
        .err       (err)
`ifdef CALC_SEQ_STATS_EN
        ,
        .op_count  (op_count),
        .drop_count(drop_count)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_cmd(input int kind, input int val);
        sbq.push_back(kind * 16 + val);
    endtask

    task automatic sb_cmp(input string tag, input int code);
        int exp;
        exp = (sbq.size() > 0) ? sbq.pop_front() : 32'hFFFF;
        check(tag, code, exp);
    endtask

    function automatic logic [31:0] outs();
        return {17'd0, ev_drop, hex_we, hex_val, bs_we, push_we, ans_we, clr_we,
                alu_start, alu_op, busy, err};
    endfunction

    // Called at a falling edge; holds the event for one cycle
    task automatic send(input logic [1:0] t, input logic [3:0] d);
        ev_valid = 1'b1;
        ev_type  = t;
        ev_data  = d;
        @(negedge clock);
        ev_valid = 1'b0;
    endtask

    task automatic wait_start(input string tag);
        int n;
        n = 0;
        while (alu_start !== 1'b1 && n < 50) begin
            @(negedge clock);
            n++;
        end
        check(tag, alu_start, 1);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 200) begin
            @(negedge clock);
            n++;
        end
        check(tag, busy, 0);
    endtask

    // Command monitor: exclusivity and in-order scoreboard comparison
    initial begin
        int ncmd;
        forever begin
            @(negedge clock);
            if (reset !== 1'b1) begin
                if (ev_drop === 1'b1) drops_seen++;
                ncmd = int'(hex_we) + int'(bs_we) + int'(push_we) + int'(ans_we) + int'(clr_we);
                if (ncmd != 0) check("cmd_exclusive", ncmd, 1);
                if (hex_we === 1'b1)    sb_cmp("sb_hex",   K_HEX * 16 + int'(hex_val));
                if (bs_we === 1'b1)     sb_cmp("sb_bs",    K_BS * 16);
                if (push_we === 1'b1)   sb_cmp("sb_push",  K_PUSH * 16);
                if (ans_we === 1'b1)    sb_cmp("sb_ans",   K_ANS * 16);
                if (clr_we === 1'b1)    sb_cmp("sb_clr",   K_CLR * 16);
                if (alu_start === 1'b1) sb_cmp("sb_start", K_START * 16 + int'(alu_op));
            end
        end
    end

    // Arithmetic unit model: answers alu_lat cycles after alu_start
    initial begin
        int cd;
        bit chk_pending;
        int chk_mode;
        cd = 0;
        chk_pending = 0;
        chk_mode = 0;
        alu_done = 1'b0;
        alu_ovw  = 1'b0;
        forever begin
            @(negedge clock);
            if (chk_pending) begin
                chk_pending = 0;
                if (chk_mode == 0) begin
                    check("ans_after_done", ans_we, 1);
                end else begin
                    check("ovw_err", err, 1);
                    check("ovw_no_ans", ans_we, 0);
                end
            end
            alu_done = force_done;
            alu_ovw  = 1'b0;
            if (reset === 1'b1) begin
                cd = 0;
            end else if (alu_start === 1'b1 && alu_mode != 2) begin
                cd = alu_lat;
            end else if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    alu_done    = 1'b1;
                    alu_ovw     = (alu_mode == 1);
                    chk_pending = 1;
                    chk_mode    = alu_mode;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset    = 1'b1;
        ev_valid = 1'b0;
        ev_type  = '0;
        ev_data  = '0;
        repeat (2) @(negedge clock);
        check("reset_outputs", outs(), 0);
        reset = 1'b0;
        @(negedge clock);

        // Plain digits: two edges from ev_valid to the hex_we pulse
        expect_cmd(K_HEX, 3);
        send(EV_HEX, 4'd3);
        check("t1_not_early", hex_we, 0);
        @(negedge clock);
        check("t1_hex3", {hex_we, hex_val}, {1'b1, 4'd3});
        repeat (2) @(negedge clock);
        expect_cmd(K_HEX, 7);
        send(EV_HEX, 4'd7);
        @(negedge clock);
        check("t1_hex7", {hex_we, hex_val}, {1'b1, 4'd7});
        check("t1_busy", busy, 0);

        // 5 + 2 =
        alu_mode = 0;
        alu_lat  = 5;
        expect_cmd(K_HEX, 5);
        expect_cmd(K_PUSH, 0);
        expect_cmd(K_HEX, 2);
        expect_cmd(K_START, 1);
        expect_cmd(K_ANS, 0);
        send(EV_HEX, 4'd5);
        send(EV_OP, 4'd1);
        send(EV_HEX, 4'd2);
        send(EV_EQ, 4'd0);
        wait_start("t2_start");
        wait_idle("t2_idle");
        repeat (4) @(negedge clock);
        check("t2_busy_after", busy, 0);
        check("t2_sb_drained", sbq.size(), 0);

        // Chained operators with digits queued during the computation
        alu_lat = 10;
        expect_cmd(K_PUSH, 0);
        expect_cmd(K_START, 0);
        expect_cmd(K_ANS, 0);
        expect_cmd(K_PUSH, 0);
        send(EV_OP, 4'd0);
        send(EV_OP, 4'd2);
        wait_start("t3_start");
        expect_cmd(K_HEX, 1);
        expect_cmd(K_HEX, 2);
        expect_cmd(K_HEX, 3);
        send(EV_HEX, 4'd1);
        send(EV_HEX, 4'd2);
        send(EV_HEX, 4'd3);
        check("t3_busy_in_wait", busy, 1);
        wait_idle("t3_idle");
        repeat (6) @(negedge clock);
        check("t3_sb_drained", sbq.size(), 0);
        check("t3_no_drop", drops_seen, 0);

        // Overfill the FIFO while the ALU is busy
        alu_lat = 20;
        expect_cmd(K_START, 2);
        expect_cmd(K_ANS, 0);
        send(EV_EQ, 4'd0);
        wait_start("t4_start");
        for (int i = 4; i < 8; i++) begin
            expect_cmd(K_HEX, i);
            send(EV_HEX, 4'(i));
        end
        check("t4_no_drop_at_4", ev_drop, 0);
        send(EV_HEX, 4'd8);
        check("t4_drop_5th", ev_drop, 1);
        @(negedge clock);
        check("t4_drop_one_cycle", ev_drop, 0);
        wait_idle("t4_idle");
        repeat (8) @(negedge clock);
        check("t4_sb_drained", sbq.size(), 0);
        check("t4_drop_count_seen", drops_seen, 1);
`ifdef CALC_SEQ_STATS_EN
        check("t4_stat_drop", drop_count, 1);
        check("t4_stat_ops", op_count, 3);
`endif

        // ALU never answers: timeout to ERROR, recover with backspace
        alu_mode = 2;
        expect_cmd(K_PUSH, 0);
        send(EV_OP, 4'd3);
        expect_cmd(K_START, 3);
        send(EV_EQ, 4'd0);
        wait_start("t5_start");
        n = 0;
        while (err !== 1'b1 && n < 100) begin
            @(negedge clock);
            n++;
        end
        check("t5_timeout_cycles", n, 65);
        check("t5_busy_err", busy, 1);
        send(EV_HEX, 4'd9);
        repeat (3) @(negedge clock);
        check("t5_err_held", err, 1);
        check("t5_hex_discarded", sbq.size(), 0);
        expect_cmd(K_CLR, 0);
        send(EV_BS, 4'd0);
        @(negedge clock);
        check("t5_clr", clr_we, 1);
        @(negedge clock);
        check("t5_recovered", {busy, err}, 2'b00);

        // Overflowed result: error, no answer load
        alu_mode = 1;
        alu_lat  = 3;
        expect_cmd(K_PUSH, 0);
        send(EV_OP, 4'd1);
        expect_cmd(K_START, 1);
        send(EV_EQ, 4'd0);
        wait_start("t6_start");
        repeat (6) @(negedge clock);
        check("t6_err", err, 1);
        expect_cmd(K_CLR, 0);
        send(EV_BS, 4'd0);
        repeat (3) @(negedge clock);
        check("t6_recovered", {busy, err}, 2'b00);

        // Reset in WAIT, then a stray alu_done
        alu_mode = 2;
        expect_cmd(K_PUSH, 0);
        send(EV_OP, 4'd2);
        expect_cmd(K_START, 2);
        send(EV_EQ, 4'd0);
        wait_start("t7_start");
        repeat (3) @(negedge clock);
        check("t7_busy_pre", busy, 1);
        #3 reset = 1'b1;
        #1 check("t7_async_reset", outs(), 0);
        sbq.delete();
        @(negedge clock);
        reset = 1'b0;
        #1 force_done = 1'b1;
        @(negedge clock);
        #1 force_done = 1'b0;
        repeat (4) @(negedge clock);
        check("t7_late_done_ignored", {busy, err, ans_we}, 3'b000);
        send(EV_EQ, 4'd0);
        repeat (4) @(negedge clock);
        check("t7_eq_no_pending", busy, 0);
        expect_cmd(K_HEX, 10);
        send(EV_HEX, 4'd10);
        repeat (3) @(negedge clock);
        check("t7_sb_drained", sbq.size(), 0);
        check("final_drops", drops_seen, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/calc_sequencer.md
Name: calc_sequencer

Overview:
Control FSM that sequences the calculator datapath from decoded key events.
- Buffers events in a small FIFO, so keypresses arriving during a multi-cycle ALU operation are not lost.
- Issues one-cycle register-file commands: digit shift, backspace, push, answer load, clear.
- Drives a start/done handshake to the arithmetic unit.
- Sits between the keypad interpreter and the Registers / arithmetic blocks inside Calculator.

Parameters:
FIFO_DEPTH, 4, event FIFO entries (power of two, >=2)
ALU_TIMEOUT, 64, max cycles WAIT waits for alu_done before ERROR

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
ev_valid  in  1  one-cycle event strobe
ev_type  in  2  0=HEX, 1=OP, 2=EQ, 3=BS
ev_data  in  4  hexcode for HEX; [1:0] opcode for OP; ignored otherwise
ev_drop  out  1  one-cycle pulse: event discarded because FIFO full
hex_we  out  1  shift hex_val into V1
hex_val  out  4  digit accompanying hex_we
bs_we  out  1  backspace V1
push_we  out  1  V2<=V1, V1<=0
ans_we  out  1  V1<=answer
clr_we  out  1  V1<=0, V2<=0
alu_start  out  1  one-cycle start pulse
alu_op  out  2  opcode; held stable from alu_start until alu_done
alu_done  in  1  one-cycle completion strobe from the arithmetic unit
alu_ovw  in  1  overflow flag, valid with alu_done
busy  out  1  high in any state other than IDLE
err  out  1  high while in ERROR

Behaviour:
- Architecture: all outputs registered.
- Reset values: every output 0, FIFO empty, pend_valid=0, pend_op=0, state IDLE.
- FIFO write: ev_valid with FIFO not full writes at edge N.
- FIFO full: ev_valid when full and no pop in the same cycle -> event dropped, ev_drop=1 in the following cycle.
- Full with simultaneous pop: the write is accepted.
- Dispatch latency: IDLE with FIFO non-empty pops the head at the next edge. The resulting command pulse is high for exactly the one cycle following the pop edge. An event into an idle, empty FIFO at edge N gives its pulse in cycle N+1..N+2.
- IDLE, HEX pop -> hex_we=1, hex_val=data; stay IDLE.
- IDLE, BS pop -> bs_we=1; stay IDLE.
- IDLE, OP pop, pend_valid=0 -> push_we=1, pend_op<=data[1:0], pend_valid<=1.
- IDLE, OP pop, pend_valid=1 -> START with chain=1, next_op<=data[1:0].
- IDLE, EQ pop, pend_valid=1 -> START with chain=0.
- IDLE, EQ pop, pend_valid=0 -> no command.
- START: alu_start=1, alu_op=pend_op; go to WAIT with timeout counter cleared.
- WAIT: increment counter every cycle.
  - alu_done & !alu_ovw -> WRITE.
  - alu_done & alu_ovw -> ERROR; answer not loaded.
  - Counter reaches ALU_TIMEOUT without alu_done -> ERROR.
- WRITE: ans_we=1.
  - chain=1 -> PUSH.
  - chain=0 -> pend_valid<=0, IDLE.
- PUSH: push_we=1, pend_op<=next_op, pend_valid stays 1; go to IDLE.
- ERROR: err=1. Pops continue one per cycle.
  - HEX/OP/EQ events are discarded.
  - BS -> clr_we=1, pend_valid<=0, IDLE.
- Command exclusivity: at most one of hex_we/bs_we/push_we/ans_we/clr_we is high in any cycle.
- FIFO during computation: the FIFO keeps accepting events in all states; only IDLE and ERROR pop.
- alu_done outside WAIT is ignored.
- Reset mid-operation returns to IDLE immediately. A late alu_done after reset is ignored.

Optional Feature:
CALC_SEQ_STATS_EN
- Defined: adds output op_count (8 bits, reset 0), incremented on each WRITE entry, saturating at 255.
- Defined: adds output drop_count (4 bits, reset 0), incremented with each ev_drop, saturating at 15.
- Undefined: neither port nor counter exists; behaviour is otherwise identical.

Decomposition:
- Package calc_seq_pkg:
  - ev_type encodings EV_HEX/EV_OP/EV_EQ/EV_BS.
  - state enum IDLE/START/WAIT/WRITE/PUSH/ERROR.
  - opcode width constant OPW=2.
  - event record {type, data}.
- Sub-module calc_event_fifo: parameterised FIFO_DEPTH, 6-bit entries, push/pop/full/empty, same clock and async reset.

Test Plan:
- Reset, then HEX 3 and HEX 7 spaced 4 cycles -> hex_we pulses with hex_val 3 then 7, each two edges after ev_valid; push_we, ans_we and alu_start stay 0.
- HEX 5, OP 1, HEX 2, EQ; model ALU returns alu_done after 5 cycles -> one push_we, one alu_start with alu_op=1, then ans_we one cycle after alu_done; busy 0 afterwards, pend_valid cleared.
- OP 0, OP 2 back-to-back with ALU busy 10 cycles, plus 3 HEX queued during WAIT -> ans_we, then push_we, then the 3 queued hex_we in order. No ev_drop with FIFO_DEPTH=4.
- Fill the FIFO during WAIT with 5 events at DEPTH 4 -> exactly one ev_drop on the 5th; with the stats macro defined, drop_count=1.
- ALU never answers -> err=1 after 64 WAIT cycles; a HEX is discarded; a BS gives clr_we, err=0, state IDLE.
- alu_done with alu_ovw=1 -> no ans_we, err=1. Assert reset during WAIT -> all outputs 0 asynchronously, and a following alu_done is ignored.
